// File: rtl/hazard_scoreboard.sv
// Operand hazard scoreboard for the 5-stage pipeline: stall and bypass selects
// from decoded producer/consumer timing, plus an MDU busy counter for HI/LO.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs_addr,
    input  logic              d_rs_used,
    input  logic [TNEW_W-1:0] d_rs_tuse,
    input  logic [REG_AW-1:0] d_rt_addr,
    input  logic              d_rt_used,
    input  logic [TNEW_W-1:0] d_rt_tuse,
    input  logic [REG_AW-1:0] d_dst_addr,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_is_div,
    input  logic              d_md_use,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic              md_busy
);

    typedef logic [REG_AW-1:0] reg_t;
    typedef logic [TNEW_W-1:0] tn_t;

    typedef struct packed {
        reg_t dst;
        tn_t  tnew;
        reg_t rs;
        logic rs_used;
        reg_t rt;
        logic rt_used;
    } rec_t;

    rec_t e_q, m_q, w_q;
    rec_t e_nxt, m_nxt, w_nxt;
    logic [CNT_W-1:0] md_cnt;
    logic data_stall, md_stall, advance;

    function automatic tn_t tn_dec(input tn_t t);
        return (t != '0) ? t - TNEW_W'(1) : '0;
    endfunction

    // Register 0 is never a real destination, so it never matches.
    function automatic logic hit(input rec_t r, input reg_t s);
        return (r.dst != '0) && (r.dst == s);
    endfunction

    function automatic logic src_stall(
        input logic used, input reg_t s, input tn_t tuse,
        input rec_t e, input rec_t m);
        logic se, sm;
        se = hit(e, s) && (e.tnew > tuse);
        sm = hit(m, s) && (m.tnew > tuse);
        return used && (s != '0) && (se || sm);
    endfunction

    // The youngest match decides; a not-yet-ready match blocks older stages.
    function automatic logic [1:0] fwd_d(
        input logic used, input reg_t s,
        input rec_t e, input rec_t m, input rec_t w);
        logic [1:0] sel;
        sel = 2'd0;
        if (used && s != '0) begin
            if (hit(e, s))
                sel = (e.tnew == '0) ? 2'd1 : 2'd0;
            else if (hit(m, s))
                sel = (m.tnew == '0) ? 2'd2 : 2'd0;
            else if (hit(w, s))
                sel = (w.tnew == '0) ? 2'd3 : 2'd0;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e(
        input logic used, input reg_t s,
        input rec_t m, input rec_t w);
        logic [1:0] sel;
        sel = 2'd0;
        if (used && s != '0) begin
            if (hit(m, s))
                sel = (m.tnew == '0) ? 2'd2 : 2'd0;
            else if (hit(w, s))
                sel = (w.tnew == '0) ? 2'd3 : 2'd0;
        end
        return sel;
    endfunction

    assign md_busy = (md_cnt != '0);

    always_comb begin
        data_stall = src_stall(d_rs_used, d_rs_addr, d_rs_tuse, e_q, m_q)
                   | src_stall(d_rt_used, d_rt_addr, d_rt_tuse, e_q, m_q);
        md_stall   = d_valid && d_md_use && md_busy;
        stall      = data_stall || md_stall;
        advance    = d_valid && !stall;
    end

    always_comb begin
        fwd_rs_d = fwd_d(d_rs_used, d_rs_addr, e_q, m_q, w_q);
        fwd_rt_d = fwd_d(d_rt_used, d_rt_addr, e_q, m_q, w_q);
        fwd_rs_e = fwd_e(e_q.rs_used, e_q.rs, m_q, w_q);
        fwd_rt_e = fwd_e(e_q.rt_used, e_q.rt, m_q, w_q);
        fwd_rt_m = m_q.rt_used && (m_q.rt != '0) && (w_q.dst == m_q.rt);
    end

    always_comb begin
        e_nxt = '0;
        if (advance) begin
            e_nxt.dst     = d_dst_addr;
            e_nxt.tnew    = d_tnew;
            e_nxt.rs      = d_rs_addr;
            e_nxt.rs_used = d_rs_used;
            e_nxt.rt      = d_rt_addr;
            e_nxt.rt_used = d_rt_used;
        end
        m_nxt      = e_q;
        m_nxt.tnew = tn_dec(e_q.tnew);
        w_nxt      = m_q;
        w_nxt.tnew = tn_dec(m_q.tnew);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_nxt;
            m_q <= m_nxt;
            w_q <= w_nxt;
        end
    end

    // A start is only taken when D actually advances, never while stalled.
    always_ff @(posedge clk) begin
        if (reset)
            md_cnt <= '0;
        else if (advance && d_md_start)
            md_cnt <= d_md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - CNT_W'(1);
    end

endmodule
